// File: rtl/mmio_pkg.sv
// Shared types and address-decode helper for the MMIO write arbiter.
package mmio_pkg;

    localparam logic [31:0] LED_BASE_DEFAULT = 32'h0000_3000;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_txn_t;

    // True when addr falls inside the byte range spanned by num_words registers starting at base.
    function automatic logic is_led_addr(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned num_words);
        logic [31:0] offset;
        offset = addr - base;
        return (addr >= base) && (offset < (32'(num_words) << 2));
    endfunction

endpackage

// File: rtl/mmio_rr_arb2.sv
// Two-requester round-robin grant with a bus-lock mode that lets requester 1 own the path across beats.
module mmio_rr_arb2
    import mmio_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       lock_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    arb_state_t state_q, state_d;
    logic       last_grant_q, last_grant_d;

    always_ff @(posedge clk) begin
        // NOTE: registers use <= so every flop samples pre-edge values regardless of statement order.
        if (!rst) begin
            state_q      <= ARB;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        // NOTE: default first so no branch leaves grant_o unassigned and a latch is never inferred.
        grant_o = 2'b00;
        unique case (state_q)
            ARB: begin
                if (req0_i && req1_i) begin
                    grant_o = last_grant_q ? 2'b01 : 2'b10;
                end else begin
                    grant_o = {req1_i, req0_i};
                end
            end
            LOCK:    grant_o = {req1_i, 1'b0};
            default: grant_o = 2'b00;
        endcase
    end

    // Kept apart from the grant process: accept_i itself depends on grant_o.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        if (accept_i) begin
            last_grant_d = grant_o[1];
        end
        unique case (state_q)
            ARB: begin
                if (accept_i && grant_o[1] && lock_i) begin
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if ((accept_i && !lock_i) || (!req1_i && !lock_i)) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

endmodule

// File: rtl/mmio_write_arbiter.sv
// Shares one MMIO write path between the core (m0) and a debug master (m1); owns the LED bank.
// Optional MMIO_LED_BLINK_EN adds a blink-mask register after the LED bits and a blink prescaler.
module mmio_write_arbiter
    import mmio_pkg::*;
#(
    parameter logic [31:0] LED_BASE  = LED_BASE_DEFAULT,
    parameter int unsigned LED_COUNT = 8
`ifdef MMIO_LED_BLINK_EN
    ,
    parameter int unsigned BLINK_DIV = 24
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m0_valid,
    output logic                 m0_ready,
    input  logic [31:0]          m0_addr,
    input  logic [31:0]          m0_data,
    input  logic                 m1_valid,
    output logic                 m1_ready,
    input  logic                 m1_lock,
    input  logic [31:0]          m1_addr,
    input  logic [31:0]          m1_data,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_data,
    output logic [LED_COUNT-1:0] led,
    output logic                 err
);

`ifdef MMIO_LED_BLINK_EN
    localparam int unsigned LED_WORDS = LED_COUNT + 1;
`else
    localparam int unsigned LED_WORDS = LED_COUNT;
`endif

    wr_txn_t              m0_txn, m1_txn, sel_txn;
    wr_txn_t              slot_q, slot_d;
    logic                 mem_valid_q, mem_valid_d;
    logic [LED_COUNT-1:0] led_q, led_d;
    logic                 err_q, err_d;
    logic [1:0]           grant;
    logic                 m0_is_led, m1_is_led, sel_is_led;
    logic                 slot_free, accept;
    logic [31:0]          sel_offset;
    logic [29:0]          sel_word;
    logic                 sel_misaligned;
`ifdef MMIO_LED_BLINK_EN
    logic [LED_COUNT-1:0] mask_q, mask_d;
`endif

    assign m0_txn    = '{addr: m0_addr, data: m0_data};
    assign m1_txn    = '{addr: m1_addr, data: m1_data};
    assign m0_is_led = is_led_addr(m0_addr, LED_BASE, LED_WORDS);
    assign m1_is_led = is_led_addr(m1_addr, LED_BASE, LED_WORDS);

    mmio_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req0_i   (m0_valid),
        .req1_i   (m1_valid),
        .lock_i   (m1_lock),
        .accept_i (accept),
        .grant_o  (grant)
    );

    // LED beats bypass the slot, so a stalled downstream never blocks them.
    assign slot_free = !mem_valid_q || mem_ready;
    assign m0_ready  = grant[0] && (m0_is_led || slot_free);
    assign m1_ready  = grant[1] && (m1_is_led || slot_free);
    assign accept    = (m0_valid && m0_ready) || (m1_valid && m1_ready);

    assign sel_txn        = grant[1] ? m1_txn : m0_txn;
    assign sel_is_led     = grant[1] ? m1_is_led : m0_is_led;
    assign sel_offset     = sel_txn.addr - LED_BASE;
    assign sel_word       = sel_offset[31:2];
    assign sel_misaligned = (sel_offset[1:0] != 2'b00);

    always_comb begin
        slot_d      = slot_q;
        mem_valid_d = mem_valid_q && !mem_ready;
        led_d       = led_q;
        err_d       = err_q;
`ifdef MMIO_LED_BLINK_EN
        mask_d      = mask_q;
`endif
        if (accept) begin
            if (!sel_is_led) begin
                slot_d      = sel_txn;
                mem_valid_d = 1'b1;
            end else if (sel_misaligned) begin
                err_d = 1'b1;
            end else begin
                for (int unsigned n = 0; n < LED_COUNT; n++) begin
                    if (sel_word == 30'(n)) begin
                        led_d[n] = sel_txn.data[0];
                    end
                end
`ifdef MMIO_LED_BLINK_EN
                if (sel_word == 30'(LED_COUNT)) begin
                    mask_d = sel_txn.data[LED_COUNT-1:0];
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_q      <= '0;
            mem_valid_q <= 1'b0;
            led_q       <= '0;
            err_q       <= 1'b0;
`ifdef MMIO_LED_BLINK_EN
            mask_q      <= '0;
`endif
        end else begin
            slot_q      <= slot_d;
            mem_valid_q <= mem_valid_d;
            led_q       <= led_d;
            err_q       <= err_d;
`ifdef MMIO_LED_BLINK_EN
            mask_q      <= mask_d;
`endif
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = slot_q.addr;
    assign mem_data  = slot_q.data;
    assign err       = err_q;

`ifdef MMIO_LED_BLINK_EN
    logic [BLINK_DIV-1:0] prescale_q;
    logic                 phase_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prescale_q <= '0;
            phase_q    <= 1'b0;
        end else begin
            prescale_q <= prescale_q + BLINK_DIV'(1);
            if (&prescale_q) begin
                phase_q <= !phase_q;
            end
        end
    end

    assign led = led_q ^ (mask_q & {LED_COUNT{phase_q}});
`else
    assign led = led_q;
`endif

endmodule

// File: tb/tb_mmio_write_arbiter.sv
// Randomized self-checking bench for mmio_write_arbiter against a transaction-level reference model.
module tb_mmio_write_arbiter;

    localparam int          LED_COUNT = 8;
    localparam logic [31:0] LED_BASE  = 32'h0000_3000;
`ifdef MMIO_LED_BLINK_EN
    localparam int BLINK_DIV = 2;
    localparam int LED_WORDS = LED_COUNT + 1;
`else
    localparam int LED_WORDS = LED_COUNT;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 m0_valid, m0_ready, m1_valid, m1_ready, m1_lock;
    logic [31:0]          m0_addr, m0_data, m1_addr, m1_data;
    logic                 mem_valid, mem_ready;
    logic [31:0]          mem_addr, mem_data;
    logic [LED_COUNT-1:0] led;
    logic                 err;

    always #5 clk = ~clk;

    mmio_write_arbiter #(
        .LED_BASE  (LED_BASE),
        .LED_COUNT (LED_COUNT)
`ifdef MMIO_LED_BLINK_EN
        ,
        .BLINK_DIV (BLINK_DIV)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_valid  (m0_valid),
        .m0_ready  (m0_ready),
        .m0_addr   (m0_addr),
        .m0_data   (m0_data),
        .m1_valid  (m1_valid),
        .m1_ready  (m1_ready),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_data   (m1_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .led       (led),
        .err       (err)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending downstream writes, arbitration history, LED/mask/err contents.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t                 slot[$];
    bit                   locked      = 1'b0;
    int                   last_winner = 1;
    bit [LED_COUNT-1:0]   m_led       = '0;
    bit [LED_COUNT-1:0]   m_mask      = '0;
    bit                   m_err       = 1'b0;
    int                   edges       = 0;
    bit                   acc0, acc1;
    logic                 obs_r0, obs_r1;

    function automatic bit in_window(input logic [31:0] a);
        return (a >= LED_BASE) && (a < LED_BASE + 32'(4 * LED_WORDS));
    endfunction

    // Checks the DUT for one cycle against the model, then advances the model across the edge.
    task automatic tick();
        int                 winner;
        int                 idx;
        bit                 ok;
        bit                 phase;
        logic [31:0]        waddr, wdata;
        bit [LED_COUNT-1:0] exp_led;
        #1;
        winner = -1;
        if (locked) begin
            if (m1_valid) winner = 1;
        end else if (m0_valid && m1_valid) begin
            winner = (last_winner == 1) ? 0 : 1;
        end else if (m0_valid) begin
            winner = 0;
        end else if (m1_valid) begin
            winner = 1;
        end
        waddr = (winner == 1) ? m1_addr : m0_addr;
        wdata = (winner == 1) ? m1_data : m0_data;
        ok    = (winner >= 0) && (in_window(waddr) || slot.size() == 0 || mem_ready);

`ifdef MMIO_LED_BLINK_EN
        phase = ((edges >> BLINK_DIV) & 1) != 0;
`else
        phase = 1'b0;
`endif
        exp_led = m_led ^ (m_mask & {LED_COUNT{phase}});

        obs_r0 = m0_ready;
        obs_r1 = m1_ready;
        check("m0_ready", m0_ready, 32'(ok && winner == 0));
        check("m1_ready", m1_ready, 32'(ok && winner == 1));
        check("mem_valid", mem_valid, 32'(slot.size() != 0));
        if (slot.size() != 0) begin
            check("mem_addr", mem_addr, slot[0].addr);
            check("mem_data", mem_data, slot[0].data);
        end
        check("led", 32'(led), 32'(exp_led));
        check("err", err, 32'(m_err));

        @(posedge clk);
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (!rst) begin
            slot.delete();
            locked      = 1'b0;
            last_winner = 1;
            m_led       = '0;
            m_mask      = '0;
            m_err       = 1'b0;
            edges       = 0;
        end else begin
            edges++;
            if (slot.size() != 0 && mem_ready) void'(slot.pop_front());
            if (ok) begin
                acc0        = (winner == 0);
                acc1        = (winner == 1);
                last_winner = winner;
                if (!in_window(waddr)) begin
                    slot.push_back('{addr: waddr, data: wdata});
                end else if (waddr[1:0] != 2'b00) begin
                    m_err = 1'b1;
                end else begin
                    idx = int'((waddr - LED_BASE) >> 2);
                    if (idx < LED_COUNT) m_led[idx] = wdata[0];
                    else                 m_mask     = wdata[LED_COUNT-1:0];
                end
            end
            if (!locked) begin
                if (acc1 && m1_lock) locked = 1'b1;
            end else if ((acc1 && !m1_lock) || (!m1_valid && !m1_lock)) begin
                locked = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_m0(input logic v, input logic [31:0] a, input logic [31:0] d);
        m0_valid = v;
        m0_addr  = a;
        m0_data  = d;
    endtask

    task automatic set_m1(input logic v, input logic lk, input logic [31:0] a, input logic [31:0] d);
        m1_valid = v;
        m1_lock  = lk;
        m1_addr  = a;
        m1_data  = d;
    endtask

    task automatic do_reset();
        set_m0(1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = int'($urandom_range(0, 19));
        if (sel < 8)        return LED_BASE + 32'(4 * $urandom_range(0, LED_WORDS - 1));
        else if (sel == 8)  return LED_BASE + 32'(4 * $urandom_range(0, LED_WORDS - 1)) + 32'($urandom_range(1, 3));
        else if (sel == 9)  return LED_BASE + 32'(4 * LED_COUNT);
        else if (sel == 10) return LED_BASE - 32'd4;
        else                return $urandom & 32'h0000_FFFC;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int toggles;
        logic prev;

        rst       = 1'b0;
        mem_ready = 1'b1;
        set_m0(1'b0, 32'h0, 32'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Reset state.
        #1;
        check("rst_led", 32'(led), 32'h0);
        check("rst_err", err, 32'h0);
        check("rst_mem_valid", mem_valid, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_data", mem_data, 32'h0);

        // LED write sets bit 2, then clears it, with no downstream traffic.
        set_m0(1'b1, 32'h3008, 32'h1);
        tick();
        check("t1_accept", obs_r0, 32'h1);
        set_m0(1'b0, 32'h0, 32'h0);
        check("t1_led_set", 32'(led), 32'h04);
        check("t1_no_mem", mem_valid, 32'h0);
        set_m0(1'b1, 32'h3008, 32'h0);
        tick();
        set_m0(1'b0, 32'h0, 32'h0);
        check("t1_led_clr", 32'(led), 32'h00);

        // Round-robin with both masters streaming and no backpressure.
        do_reset();
        mem_ready = 1'b1;
        set_m0(1'b1, 32'h0100, 32'hA0A0_0000);
        set_m1(1'b1, 1'b0, 32'h0200, 32'hB1B1_0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_m0_turn", obs_r0, 32'(i % 2 == 0));
            check("t2_mem_valid", mem_valid, 32'h1);
            check("t2_mem_addr", mem_addr, (i % 2 == 0) ? 32'h0100 : 32'h0200);
        end
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("t2_tail", mem_addr, 32'h0100);

        // Backpressure: slot stalls m0 while an m1 LED write still gets through.
        mem_ready = 1'b0;
        set_m0(1'b1, 32'h0180, 32'h0000_00AA);
        set_m1(1'b1, 1'b0, 32'h301C, 32'h1);
        tick();
        check("t3_led_accept", obs_r1, 32'h1);
        check("t3_m0_stall", obs_r0, 32'h0);
        check("t3_led7", 32'(led[7]), 32'h1);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_m0_held", obs_r0, 32'h0);
            check("t3_slot_addr", mem_addr, 32'h0100);
            check("t3_slot_valid", mem_valid, 32'h1);
        end
        mem_ready = 1'b1;
        tick();
        check("t3_release", obs_r0, 32'h1);
        check("t3_new_addr", mem_addr, 32'h0180);
        check("t3_new_valid", mem_valid, 32'h1);
        set_m0(1'b0, 32'h0, 32'h0);
        tick();

        // Locked burst from m1 starves m0 until the unlocking beat.
        set_m0(1'b1, 32'h0104, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            set_m1(1'b1, (i < 3), 32'h0200 + 32'(4 * i), 32'(i));
            tick();
            check("t4_m1_beat", obs_r1, 32'h1);
            check("t4_m0_blocked", obs_r0, 32'h0);
        end
        set_m1(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("t4_m0_after", obs_r0, 32'h1);
        set_m0(1'b0, 32'h0, 32'h0);
        tick();

        // Misaligned LED write: accepted, dropped, sticky err until reset.
        set_m0(1'b1, 32'h3006, 32'h1);
        tick();
        check("t5_accept", obs_r0, 32'h1);
        set_m0(1'b0, 32'h0, 32'h0);
        check("t5_err", err, 32'h1);
        check("t5_led_same", 32'(led), 32'h80);
        repeat (3) tick();
        check("t5_err_sticky", err, 32'h1);
        do_reset();
        check("t5_err_clr", err, 32'h0);
        check("t5_led_clr", 32'(led), 32'h0);

`ifdef MMIO_LED_BLINK_EN
        // Blink mask on bit 0: led[0] toggles every 2^BLINK_DIV cycles; reset stops it at once.
        set_m0(1'b1, LED_BASE + 32'(4 * LED_COUNT), 32'h1);
        tick();
        set_m0(1'b0, 32'h0, 32'h0);
        toggles = 0;
        prev    = led[0];
        for (int i = 0; i < 16; i++) begin
            tick();
            if (led[0] !== prev) toggles++;
            prev = led[0];
        end
        check("t6_toggles", 32'(toggles), 32'd4);
        for (int i = 0; i < 8 && led[0] !== 1'b1; i++) tick();
        check("t6_lit", 32'(led[0]), 32'h1);
        do_reset();
        check("t6_rst_led", 32'(led), 32'h0);
`endif

        // Randomized traffic with backpressure, locks and occasional reset.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst       = 1'b1;
            mem_ready = ($urandom_range(0, 99) < 70);
            if (acc0) m0_valid = 1'b0;
            if (acc1) begin
                m1_valid = 1'b0;
                m1_lock  = 1'b0;
            end
            if (!m0_valid && $urandom_range(0, 99) < 60) begin
                set_m0(1'b1, rand_addr(), $urandom);
            end
            if (!m1_valid) begin
                if ($urandom_range(0, 99) < 50) begin
                    set_m1(1'b1, ($urandom_range(0, 2) == 0), rand_addr(), $urandom);
                end else begin
                    m1_lock = ($urandom_range(0, 3) == 0);
                end
            end
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b0;
                set_m0(1'b0, 32'h0, 32'h0);
                set_m1(1'b0, 1'b0, 32'h0, 32'h0);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
